// File: rtl/audio_pkg.sv
// Shared constants and state encoding for the audio sample player.
package audio_pkg;

    localparam int AUDIO_ADDR_W    = 14;
    localparam int AUDIO_DATA_W    = 16;
    localparam int AUDIO_ROM_DEPTH = 16384;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/audio_pwm_dac.sv
// 8-bit PWM DAC: a free-running counter is compared against the offset-binary
// top byte of the current sample. Instantiated only when AUDIO_PLAYER_PWM_EN
// is defined.
module audio_pwm_dac (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sample_hi,
    output logic       pwm_out
);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] duty;
    logic       pwm_q, pwm_d;

    // Counter wraps naturally 255 -> 0; flipping the MSB maps signed to offset binary
    always_comb begin
        cnt_d = cnt_q + 8'd1;
        duty  = sample_hi ^ 8'h80;
        pwm_d = (cnt_q < duty);
    end

    // Counter and registered comparator output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/audio_sample_player.sv
// Playback sequencer for the audio sample ROM. Steps rom_addr through
// [start_addr..end_addr] (wrapping through 0) once every CLK_DIV clocks,
// captures each ROM word into sample_out with a one-cycle sample_valid.
// Optional PWM DAC output enabled by defining AUDIO_PLAYER_PWM_EN.
module audio_sample_player
    import audio_pkg::*;
#(
    parameter int ADDR_W  = AUDIO_ADDR_W,
    parameter int DATA_W  = AUDIO_DATA_W,
    parameter int CLK_DIV = 1041,
    parameter int DIV_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              done,
    output logic              pwm_out
);

    localparam logic [DIV_W-1:0] TICK_AT = DIV_W'(CLK_DIV - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] s_q, s_d;
    logic [ADDR_W-1:0] e_q, e_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              tick;

    // Next-state logic: start/stop handling, divider and segment stepping
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        s_d      = s_q;
        e_d      = e_q;
        div_d    = div_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        tick     = (div_q == TICK_AT);

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_PLAY;
                    s_d     = start_addr;
                    e_d     = end_addr;
                    addr_d  = start_addr;
                    div_d   = '0;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    // Abort wins over start and over a coincident tick
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (start) begin
                    s_d    = start_addr;
                    e_d    = end_addr;
                    addr_d = start_addr;
                    div_d  = '0;
                end else if (tick) begin
                    div_d    = '0;
                    sample_d = rom_data;
                    valid_d  = 1'b1;
                    if (addr_q != e_q) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end else if (loop_en) begin
                        addr_d = s_q;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, all cleared by async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            s_q      <= '0;
            e_q      <= '0;
            div_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            s_q      <= s_d;
            e_q      <= e_d;
            div_q    <= div_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign rom_addr     = addr_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign done         = done_q;
    assign busy         = (state_q == ST_PLAY);

`ifdef AUDIO_PLAYER_PWM_EN
    audio_pwm_dac u_pwm (
        .clk       (clk),
        .rst       (rst),
        .sample_hi (sample_q[DATA_W-1 -: 8]),
        .pwm_out   (pwm_out)
    );
`else
    assign pwm_out = 1'b0;
`endif

endmodule

// File: doc/audio_sample_player.md
Name: audio_sample_player

Overview:
- Playback sequencer that reads the 16K-entry audio sample ROM.
- Generates ROM addresses at a programmable sample rate and captures each returned 16-bit sample.
- Presents each sample with a one-cycle valid strobe and optionally drives a PWM DAC pin.
- Sits between the player control logic (start/stop/loop) and the combinational sample ROM.

Parameters:
- ADDR_W, 14, ROM address width (16384 samples).
- DATA_W, 16, sample width; signed two's complement.
- CLK_DIV, 1041, clk cycles per sample period; legal range 2..65535 (≈24 kHz at 25 MHz).
- DIV_W, 16, width of the sample-rate divider counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin playback.
- stop  in  1  single-cycle request to abort playback.
- loop_en  in  1  level; sampled at end of segment; 1 = restart at start address.
- start_addr  in  ADDR_W  first sample address; latched when start is accepted.
- end_addr  in  ADDR_W  last sample address, inclusive; latched when start is accepted.
- rom_addr  out  ADDR_W  registered address to the sample ROM.
- rom_data  in  DATA_W  combinational ROM data for rom_addr.
- sample_out  out  DATA_W  registered current sample.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high in PLAY.
- done  out  1  one-cycle pulse on natural (non-looped) completion.
- pwm_out  out  1  PWM DAC output (see Optional Feature).

Behaviour:
- Reset values: rom_addr=0, sample_out=0, sample_valid=0, busy=0, done=0, pwm_out=0, divider=0, PWM counter=0, state=IDLE.
- FSM states are IDLE and PLAY.
- IDLE → PLAY on start=1 and stop=0 at edge N. At that edge:
  - latch start_addr/end_addr into s_reg/e_reg;
  - rom_addr<=start_addr, divider<=0, busy<=1.
- PLAY: divider increments each cycle. tick = (divider==CLK_DIV-1); on tick the divider returns to 0.
- On tick:
  - sample_out<=rom_data and sample_valid<=1 for exactly one cycle.
  - The first sample_valid is high in the cycle following edge N+CLK_DIV.
  - If rom_addr != e_reg: rom_addr<=rom_addr+1, mod 2^ADDR_W (16383 → 0).
  - If rom_addr == e_reg and loop_en=1: rom_addr<=s_reg; no done pulse.
  - If rom_addr == e_reg and loop_en=0: state<=IDLE, busy<=0, done<=1 for one cycle; rom_addr holds.
- Segment length is (e_reg - s_reg) mod 2^ADDR_W + 1 samples:
  - e_reg < s_reg wraps through address 0;
  - e_reg == s_reg plays a single sample.
- stop=1 in PLAY: IDLE at the next edge, busy<=0, no done, no sample_valid that cycle even if tick coincides. sample_out holds its last value.
- start=1 in PLAY without stop: restart. Re-latch addresses, rom_addr<=start_addr, divider<=0.
- start and stop in the same cycle: stop wins; the result is IDLE.
- stop in IDLE is ignored.
- Async rst mid-playback: all registers return immediately to their reset values.

Optional Feature:
- Macro: AUDIO_PLAYER_PWM_EN.
- Defined:
  - free-running 8-bit PWM counter, reset 0, increments every clk, wraps 255 → 0;
  - duty = sample_out[15:8] ^ 8'h80 (signed to offset binary);
  - pwm_out registered = (pwm_cnt < duty).
- Not defined: pwm_out tied to 0 and no PWM counter is synthesized. The port remains present.

Decomposition:
- Shared package audio_pkg:
  - constants AUDIO_ADDR_W=14, AUDIO_DATA_W=16, AUDIO_ROM_DEPTH=16384;
  - state enum {ST_IDLE, ST_PLAY}.
- One sub-module is natural: audio_pwm_dac, containing the 8-bit counter and comparator. It is instantiated only under AUDIO_PLAYER_PWM_EN.

Test Plan:
- Basic playback. CLK_DIV=4, ROM[i]=i, start_addr=10, end_addr=13, loop_en=0 → sample_valid pulses every 4 cycles with sample_out 10,11,12,13. The first pulse is 4 cycles after start. done pulses once alongside the last sample; then busy=0.
- Looping. Same setup with loop_en=1 for 10 ticks → samples 10,11,12,13,10,11,12,13,10,11; done never asserted. Dropping loop_en before address 13 → stop after 13 with done=1.
- Address wrap. start_addr=16382, end_addr=1 → samples ROM[16382], ROM[16383], ROM[0], ROM[1], then done.
- Stop and collisions:
  - stop mid-segment on a tick cycle → no sample_valid, busy=0 next cycle, no done, sample_out unchanged;
  - start+stop together → IDLE.
- Async reset during PLAY, asserted between clock edges → all outputs 0 immediately. A new start after deassertion plays correctly from the new start_addr.
- PWM, with AUDIO_PLAYER_PWM_EN defined:
  - sample 16'h0000 → 128/256 high cycles;
  - 16'h7FFF → 255/256;
  - 16'h8000 → 0/256.
- Without the macro, pwm_out stays 0.
